// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types, forward-select constants and width helper for the
//            pipeline hazard/forwarding controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Storage width for destination addresses; compares use only REG_AW bits.
    localparam int SB_DEST_W = 8;

    localparam int FWD_RF      = 0;
    localparam int FWD_POS_MIN = 2;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 reg_write;
        logic                 is_load;
    } sb_entry_t;

    function automatic int fwd_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : ID-stage request and hazard/forward response bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int FW     = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_reg_write;
    logic              id_is_load;
    logic              ex_br_taken;

    logic              stall;
    logic              flush_if_id;
    logic              bubble_id_ex;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dest, id_reg_write, id_is_load, ex_br_taken,
        input  stall, flush_if_id, bubble_id_ex, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dest, id_reg_write, id_is_load, ex_br_taken,
        output stall, flush_if_id, bubble_id_ex, fwd_a, fwd_b, stall_count
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : In-flight instruction shift register, one entry per stage past ID.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  issue,
    input  wire sb_entry_t             issue_entry,
    output sb_entry_t [DEPTH:1]        entries
);

    sb_entry_t [DEPTH:1] r_entries;

    // The board advances every cycle; a stall only inserts an invalid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entries <= '0;
        end else begin
            r_entries[1] <= issue ? issue_entry : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                r_entries[k] <= r_entries[k-1];
            end
        end
    end

    assign entries = r_entries;

endmodule : hazard_scoreboard
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Unified issue/stall, branch squash and EX-aligned forwarding control.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    pipeline_hazard_ctrl_if.slave   hz
);

    localparam int FW = fwd_w(DEPTH);

    generate
        if (DEPTH < 3) begin : g_bad_depth
            $error("pipeline_hazard_ctrl: DEPTH must be at least 3");
        end
        if (LOAD_RDY < FWD_POS_MIN || LOAD_RDY > DEPTH) begin : g_bad_load_rdy
            $error("pipeline_hazard_ctrl: LOAD_RDY must lie in 2..DEPTH");
        end
        if (REG_AW > SB_DEST_W) begin : g_bad_reg_aw
            $error("pipeline_hazard_ctrl: REG_AW exceeds scoreboard dest width");
        end
    endgenerate

    sb_entry_t [DEPTH:1] w_entries;
    sb_entry_t           w_issue_entry;
    logic                w_hit_a, w_rdy_a, w_hit_b, w_rdy_b;
    logic [FW-1:0]       w_sel_a, w_sel_b;
    logic                w_stall, w_bubble;
    logic [FW-1:0]       r_fwd_a, r_fwd_b;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_unused_sb;

    function automatic logic src_match(input sb_entry_t e,
                                       input logic [REG_AW-1:0] src,
                                       input logic use_src);
        return e.valid && e.reg_write && use_src &&
               (e.dest[REG_AW-1:0] == src) &&
               !((ZERO_REG != 0) && (src == '0));
    endfunction

    // Scan oldest to youngest so the youngest producer overrides. The last
    // entry is skipped: its writeback is visible through the register file.
    always_comb begin
        w_hit_a = 1'b0;
        w_rdy_a = 1'b0;
        w_sel_a = FW'(FWD_RF);
        w_hit_b = 1'b0;
        w_rdy_b = 1'b0;
        w_sel_b = FW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (src_match(w_entries[k], hz.id_rs, hz.id_use_rs)) begin
                w_hit_a = 1'b1;
                w_sel_a = FW'(k + 1);
                w_rdy_a = !w_entries[k].is_load || ((k + 1) >= LOAD_RDY);
            end
            if (src_match(w_entries[k], hz.id_rt, hz.id_use_rt)) begin
                w_hit_b = 1'b1;
                w_sel_b = FW'(k + 1);
                w_rdy_b = !w_entries[k].is_load || ((k + 1) >= LOAD_RDY);
            end
        end
    end

    assign w_stall  = hz.id_valid && !hz.ex_br_taken &&
                      ((w_hit_a && !w_rdy_a) || (w_hit_b && !w_rdy_b));
    assign w_bubble = w_stall || hz.ex_br_taken || !hz.id_valid;

    always_comb begin
        w_issue_entry           = '0;
        w_issue_entry.valid     = 1'b1;
        w_issue_entry.dest      = SB_DEST_W'(hz.id_dest);
        w_issue_entry.reg_write = hz.id_reg_write;
        w_issue_entry.is_load   = hz.id_is_load;
    end

    hazard_scoreboard #(
        .DEPTH       (DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue       (!w_bubble),
        .issue_entry (w_issue_entry),
        .entries     (w_entries)
    );

    // Some entry bits (oldest slot, upper dest bits) are intentionally unread.
    assign w_unused_sb = ^w_entries;

    // A non-bubbled issue never has an unready match, so any hit is usable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_a <= FW'(FWD_RF);
            r_fwd_b <= FW'(FWD_RF);
        end else begin
            r_fwd_a <= (w_bubble || !w_hit_a) ? FW'(FWD_RF) : w_sel_a;
            r_fwd_b <= (w_bubble || !w_hit_b) ? FW'(FWD_RF) : w_sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign hz.stall        = w_stall;
    assign hz.flush_if_id  = hz.ex_br_taken;
    assign hz.bubble_id_ex = w_bubble;
    assign hz.fwd_a        = r_fwd_a;
    assign hz.fwd_b        = r_fwd_b;
    assign hz.stall_count  = r_stall_cnt;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
